// File: rtl/div_hilo_ctrl_pkg.sv
// div_hilo_ctrl_pkg: shared word width and FSM state constants for the HI/LO divide controller
package div_hilo_ctrl_pkg;
    localparam int WORD_W = 32;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t SETTLE  = 2'd1;
    localparam state_t CAPTURE = 2'd2;
    function automatic logic is_idle(input state_t s);
        return s == IDLE;
    endfunction
endpackage

// File: rtl/div_hilo_ctrl_hilo_reg.sv
// hilo_reg: HI/LO register pair with per-half write enables, one shared write word and a divide-result load
module hilo_reg
    import div_hilo_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              clear_n,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              load,
    input  logic [WORD_W-1:0] load_hi,
    input  logic [WORD_W-1:0] load_lo,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);
    // divide result load takes priority over direct moves to HI/LO
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            hi <= '0;
            lo <= '0;
        end else if (load) begin
            hi <= load_hi;
            lo <= load_lo;
        end else begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
        end
    end
endmodule

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequences an external combinational signed divider and stores its result in HI/LO
module div_hilo_ctrl
    import div_hilo_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 4
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic [WORD_W-1:0] dividend_in,
    input  logic [WORD_W-1:0] divisor_in,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    input  logic [WORD_W-1:0] quot_in,
    input  logic [WORD_W-1:0] rem_in,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] hi_out,
    output logic [WORD_W-1:0] lo_out,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);
    localparam logic [3:0] CNT_INIT = 4'(DIV_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       idle;

    assign idle = is_idle(state);

    // FSM: accept a start in IDLE, count down settle cycles, then capture one cycle later
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (idle && start) begin
                op_a        <= dividend_in;
                op_b        <= divisor_in;
                cnt         <= CNT_INIT;
                state       <= SETTLE;
                busy        <= 1'b1;
                div_by_zero <= divisor_in == '0;
            end else if (state == SETTLE) begin
                cnt   <= (cnt == 4'd0) ? cnt : cnt - 4'd1;
                state <= (cnt == 4'd0) ? CAPTURE : SETTLE;
            end else if (state == CAPTURE) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end else if (!idle) begin
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    hilo_reg u_hilo (
        .clock   (clock),
        .clear_n (clear_n),
        .hi_we   (hi_wr && idle),
        .lo_we   (lo_wr && idle),
        .wr_data (wr_data),
        .load    (state == CAPTURE),
        .load_hi (rem_in),
        .load_lo (quot_in),
        .hi      (hi_out),
        .lo      (lo_out)
    );
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: directed self-checking bench for div_hilo_ctrl with a behavioural external divider
module tb_div_hilo_ctrl;
    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [31:0] dividend_in, divisor_in;
    logic [31:0] op_a, op_b;
    logic [31:0] quot_in, rem_in;
    logic        hi_wr, lo_wr;
    logic [31:0] wr_data;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_by_zero;
    int          checks = 0;
    int          errors = 0;

    div_hilo_ctrl #(.DIV_CYCLES(4)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .op_a        (op_a),
        .op_b        (op_b),
        .quot_in     (quot_in),
        .rem_in      (rem_in),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .wr_data     (wr_data),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    assign quot_in = (op_b == 32'd0) ? 32'd0 : 32'($signed(op_a) / $signed(op_b));
    assign rem_in  = (op_b == 32'd0) ? 32'd0 : 32'($signed(op_a) % $signed(op_b));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
        chk({tag, "_hi"}, hi_out, 32'd0);
        chk({tag, "_lo"}, lo_out, 32'd0);
        chk({tag, "_op_a"}, op_a, 32'd0);
        chk({tag, "_op_b"}, op_b, 32'd0);
    endtask

    initial begin
        clear_n = 1'b0; start = 1'b0; dividend_in = '0; divisor_in = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
        #3;
        chk_zero("reset");
        tick; tick;
        chk_zero("reset_held");
        // 100/7: release and start together, first edge with clear_n high accepts
        clear_n = 1'b1; start = 1'b1; dividend_in = 32'd100; divisor_in = 32'd7;
        tick;
        start = 1'b0; dividend_in = 32'd555; divisor_in = 32'd9;
        chk("t1_busy_e0", 32'(busy), 32'd1);
        chk("t1_op_a", op_a, 32'd100);
        chk("t1_op_b", op_b, 32'd7);
        chk("t1_dbz", 32'(div_by_zero), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("t1_busy_mid", 32'(busy), 32'd1);
            chk("t1_done_mid", 32'(done), 32'd0);
        end
        tick;
        chk("t1_busy_e5", 32'(busy), 32'd0);
        chk("t1_done_e5", 32'(done), 32'd1);
        chk("t1_lo", lo_out, 32'd14);
        chk("t1_hi", hi_out, 32'd2);
        chk("t1_op_a_hold", op_a, 32'd100);
        tick;
        chk("t1_done_e6", 32'(done), 32'd0);
        // -100/7
        start = 1'b1; dividend_in = 32'hFFFFFF9C; divisor_in = 32'd7;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 5; i++) tick;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_lo", lo_out, 32'hFFFFFFF2);
        chk("t2_hi", hi_out, 32'hFFFFFFFE);
        chk("t2_dbz", 32'(div_by_zero), 32'd0);
        // divide by zero, started back-to-back on the edge done falls
        start = 1'b1; dividend_in = 32'd9; divisor_in = 32'd0;
        tick;
        start = 1'b0;
        chk("t3_busy_b2b", 32'(busy), 32'd1);
        chk("t3_done_low", 32'(done), 32'd0);
        chk("t3_dbz_set", 32'(div_by_zero), 32'd1);
        for (int i = 1; i <= 5; i++) tick;
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_lo", lo_out, 32'd0);
        chk("t3_hi", hi_out, 32'd0);
        tick;
        chk("t3_dbz_hold", 32'(div_by_zero), 32'd1);
        // 50/5 with a start at edge 2 ignored, then 20/3 accepted at edge 6
        start = 1'b1; dividend_in = 32'd50; divisor_in = 32'd5;
        tick;
        start = 1'b0;
        chk("t4_dbz_clr", 32'(div_by_zero), 32'd0);
        tick;
        start = 1'b1; dividend_in = 32'd1000; divisor_in = 32'd1;
        tick;
        start = 1'b0;
        chk("t4_op_a_ign", op_a, 32'd50);
        tick; tick;
        chk("t4_done_e4", 32'(done), 32'd0);
        tick;
        chk("t4_done_e5", 32'(done), 32'd1);
        chk("t4_lo", lo_out, 32'd10);
        chk("t4_hi", hi_out, 32'd0);
        start = 1'b1; dividend_in = 32'd20; divisor_in = 32'd3;
        tick;
        start = 1'b0;
        chk("t4_busy_e6", 32'(busy), 32'd1);
        chk("t4_done_e6", 32'(done), 32'd0);
        for (int i = 7; i <= 10; i++) begin
            tick;
            chk("t4_done_gap", 32'(done), 32'd0);
        end
        tick;
        chk("t4_done_e11", 32'(done), 32'd1);
        chk("t4_lo2", lo_out, 32'd6);
        chk("t4_hi2", hi_out, 32'd2);
        tick;
        // direct HI/LO writes in IDLE and while busy
        hi_wr = 1'b1; wr_data = 32'hDEADBEEF;
        tick;
        hi_wr = 1'b0;
        chk("t5_hi_wr", hi_out, 32'hDEADBEEF);
        lo_wr = 1'b1; wr_data = 32'h12345678;
        tick;
        lo_wr = 1'b0;
        chk("t5_lo_wr", lo_out, 32'h12345678);
        chk("t5_hi_keep", hi_out, 32'hDEADBEEF);
        start = 1'b1; dividend_in = 32'd8; divisor_in = 32'd2;
        tick;
        start = 1'b0; hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h11111111;
        tick;
        hi_wr = 1'b0; lo_wr = 1'b0;
        chk("t5_hi_busy", hi_out, 32'hDEADBEEF);
        chk("t5_lo_busy", lo_out, 32'h12345678);
        for (int i = 2; i <= 5; i++) tick;
        chk("t5_lo_div", lo_out, 32'd4);
        chk("t5_hi_div", hi_out, 32'd0);
        tick;
        // write and start in the same IDLE cycle
        start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hAAAA5555;
        dividend_in = 32'd7; divisor_in = 32'd2;
        tick;
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        chk("t6_hi_wr", hi_out, 32'hAAAA5555);
        chk("t6_lo_wr", lo_out, 32'hAAAA5555);
        chk("t6_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 5; i++) tick;
        chk("t6_lo", lo_out, 32'd3);
        chk("t6_hi", hi_out, 32'd1);
        tick;
        // asynchronous clear in the middle of a divide
        start = 1'b1; dividend_in = 32'd100; divisor_in = 32'd0;
        tick;
        start = 1'b0;
        tick; tick;
        #2;
        clear_n = 1'b0;
        #1;
        chk_zero("t7_async");
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t7_no_done", 32'(done), 32'd0);
        end
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_hi", hi_out, 32'd0);
        chk("t7_lo", lo_out, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
